keypad_scanner: RTL

- Input-side counterpart of the 4-digit seven-segment multiplexer, for a 4x4 matrix keypad (Pmod KYPD) on Basys3.
- Drives one active-low column at a time and samples the active-low rows.
- Debounces presses and releases, then decodes the key to a 4-bit hex value.
- Its outputs feed the display digit inputs directly, so the display and keypad pair form a complete hex entry path.

---
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press/release and decodes hex.
// Optional macro KEYPAD_LAST4_EN keeps the last four accepted keys on the digits output.
module keypad_scanner #(
    parameter int SCAN_W         = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    state_t            state, state_d;
    logic [3:0]        row_meta, row_s;
    logic [SCAN_W-1:0] presc;
    logic              tick;
    logic [1:0]        ci, ci_d, ri, ri_d;
    logic [3:0]        stable_cnt, stable_d, rel_cnt, rel_d;
    logic              accept, release_done;
    logic              single_low;
    logic [1:0]        low_idx;
    logic [3:0]        new_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick = &presc;
    assign col  = ~(4'b0001 << ci);

    // Only a single low row identifies a key; two or more low rows is ghosting.
    always_comb begin
        single_low = 1'b1;
        low_idx    = 2'd0;
        case (row_s)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state;
        ci_d         = ci;
        ri_d         = ri;
        stable_d     = stable_cnt;
        rel_d        = rel_cnt;
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (single_low) begin
                        ri_d     = low_idx;
                        stable_d = 4'd1;
                        if (DB_N == 4'd1) begin
                            accept   = 1'b1;
                            state_d  = PRESSED;
                            rel_d    = 4'd0;
                            stable_d = 4'd0;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        ci_d = ci + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single_low && low_idx == ri) begin
                        stable_d = stable_cnt + 4'd1;
                        if (stable_d == DB_N) begin
                            accept   = 1'b1;
                            state_d  = PRESSED;
                            rel_d    = 4'd0;
                            stable_d = 4'd0;
                        end
                    end else begin
                        state_d  = SCAN;
                        stable_d = 4'd0;
                        ci_d     = ci + 2'd1;
                    end
                end
                PRESSED: begin
                    if (row_s == 4'b1111) begin
                        rel_d = rel_cnt + 4'd1;
                        if (rel_d == DB_N) begin
                            release_done = 1'b1;
                            state_d      = SCAN;
                            ci_d         = ci + 2'd1;
                            rel_d        = 4'd0;
                        end
                    end else begin
                        rel_d = 4'd0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Column is frozen on accept, so ci is the column of the accepted key.
    assign new_code = key_map(ri_d, ci);

    // key_valid: one-cycle pulse, no back-pressure; key_code/digits are valid in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta   <= 4'hF;
            row_s      <= 4'hF;
            presc      <= '0;
            state      <= SCAN;
            ci         <= 2'd0;
            ri         <= 2'd0;
            stable_cnt <= 4'd0;
            rel_cnt    <= 4'd0;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            row_meta   <= row;
            row_s      <= row_meta;
            presc      <= presc + 1'b1;
            state      <= state_d;
            ci         <= ci_d;
            ri         <= ri_d;
            stable_cnt <= stable_d;
            rel_cnt    <= rel_d;
            key_valid  <= accept;
            if (accept) begin
                key_code <= new_code;
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_LAST4_EN
    logic [15:0] digits_q;

    // Newest key enters the low nibble; key C clears the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= 16'h0000;
        end else if (accept) begin
            digits_q <= (new_code == 4'hC) ? 16'h0000 : {digits_q[11:0], new_code};
        end
    end

    assign digits = digits_q;
`else
    assign digits = 16'h0000;
`endif

endmodule
